// File: rtl/counter_ctrl.sv
// ============================================================================
// Module      : counter_ctrl
// Description : Start/pause/load controlled up-counter with terminal-count
//               detection, one-shot or periodic operation and a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             pause,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term,
    input  logic             mode,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam logic [1:0] c_ST_IDLE   = 2'b00;
    localparam logic [1:0] c_ST_RUN    = 2'b01;
    localparam logic [1:0] c_ST_PAUSED = 2'b10;
    localparam logic [1:0] c_ST_DONE   = 2'b11;

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             done_q;
    logic             done_d;

    logic             w_at_term;

    assign w_at_term = (count_q == term);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (start) begin
                    count_d = '0;
                    state_d = c_ST_RUN;
                end else if (load_en) begin
                    count_d = load_val;
                end
            end

            c_ST_RUN: begin
                // pause outranks both the terminal check and the increment
                if (pause) begin
                    state_d = c_ST_PAUSED;
                end else if (w_at_term) begin
                    done_d = 1'b1;
                    if (mode) begin
                        count_d = '0;
                    end else begin
                        state_d = c_ST_DONE;
                    end
                end else begin
                    count_d = count_q + c_ONE;
                end
            end

            c_ST_PAUSED: begin
                if (pause) begin
                    state_d = c_ST_PAUSED;
                end else if (start) begin
                    state_d = c_ST_RUN;
                end else if (load_en) begin
                    count_d = load_val;
                end
            end

            c_ST_DONE: begin
                // Q keeps the terminal value when falling back to IDLE
                if (start) begin
                    count_d = '0;
                    state_d = c_ST_RUN;
                end else begin
                    state_d = c_ST_IDLE;
                end
            end

            default: begin
                state_d = c_ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= c_ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign Q     = count_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q == c_ST_RUN) || (state_q == c_ST_PAUSED);

endmodule

`default_nettype wire

// File: tb/tb_counter_ctrl.sv
// ============================================================================
// Module      : tb_counter_ctrl
// Description : Directed stimulus with a queued expected-response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_ctrl;

    localparam logic [1:0] c_IDLE   = 2'b00;
    localparam logic [1:0] c_RUN    = 2'b01;
    localparam logic [1:0] c_PAUSED = 2'b10;
    localparam logic [1:0] c_DONE   = 2'b11;

    typedef struct packed {
        logic [3:0] q;
        logic       busy;
        logic       done;
        logic [1:0] st;
    } exp_t;

    logic       clock;
    logic       clear;
    logic       start;
    logic       pause;
    logic       load_en;
    logic [3:0] load_val;
    logic [3:0] term;
    logic       mode;
    logic [3:0] Q;
    logic       busy;
    logic       done;
    logic [1:0] state;

    exp_t  exp_q[$];
    string name_q[$];
    event  clr_ev;

    int n_checks;
    int n_fail;

    logic [3:0] g_term;
    logic       g_mode;
    logic       g_clear;

    counter_ctrl #(.WIDTH(4)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .pause    (pause),
        .load_en  (load_en),
        .load_val (load_val),
        .term     (term),
        .mode     (mode),
        .Q        (Q),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change on the falling edge; the expected post-edge outputs are queued
    task automatic step(input logic st, input logic pa, input logic ld,
                        input logic [3:0] lv, input logic [3:0] eq,
                        input logic eb, input logic ed, input logic [1:0] es,
                        input string nm);
        exp_t e;
        @(negedge clock);
        clear    = g_clear;
        start    = st;
        pause    = pa;
        load_en  = ld;
        load_val = lv;
        term     = g_term;
        mode     = g_mode;
        e.q = eq; e.busy = eb; e.done = ed; e.st = es;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic async_clear(input string nm);
        exp_t e;
        @(negedge clock);
        #1;
        clear   = 1'b1;
        g_clear = 1'b1;
        e.q = 4'd0; e.busy = 1'b0; e.done = 1'b0; e.st = c_IDLE;
        exp_q.push_back(e);
        name_q.push_back(nm);
        -> clr_ev;
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clock or clr_ev);
            #2;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks++;
                if (Q !== e.q || busy !== e.busy || done !== e.done || state !== e.st) begin
                    n_fail++;
                    $display("FAIL %s: got Q=%0d busy=%b done=%b state=%b, expected Q=%0d busy=%b done=%b state=%b",
                             nm, Q, busy, done, state, e.q, e.busy, e.done, e.st);
                end
            end
        end
    end

    initial begin : stimulus
        n_checks = 0;
        n_fail   = 0;
        clear    = 1'b1;
        start    = 1'b0;
        pause    = 1'b0;
        load_en  = 1'b0;
        load_val = 4'd0;
        term     = 4'd0;
        mode     = 1'b0;
        g_clear  = 1'b0;
        g_term   = 4'd3;
        g_mode   = 1'b0;

        #2;
        begin
            exp_t e;
            e.q = 4'd0; e.busy = 1'b0; e.done = 1'b0; e.st = c_IDLE;
            exp_q.push_back(e);
            name_q.push_back("reset");
            -> clr_ev;
        end

        // One-shot to term=3; start arrives on the first edge after clear drops
        step(1, 0, 0, 0,  0, 1, 0, c_RUN,  "A_start");
        step(0, 0, 0, 0,  1, 1, 0, c_RUN,  "A_cnt1");
        step(0, 0, 1, 9,  2, 1, 0, c_RUN,  "A_load_ignored");
        step(1, 0, 0, 0,  3, 1, 0, c_RUN,  "A_start_ignored");
        step(0, 0, 0, 0,  3, 0, 1, c_DONE, "A_done");
        step(0, 0, 0, 0,  3, 0, 0, c_IDLE, "A_idle");

        // Periodic with term=2
        g_term = 4'd2; g_mode = 1'b1;
        step(1, 0, 0, 0,  0, 1, 0, c_RUN,  "B_start");
        for (int i = 1; i <= 9; i++)
            step(0, 0, 0, 0, 4'(i % 3), 1, (i % 3) == 0, c_RUN, "B_periodic");

        // Pause at Q=2, then resume without reload
        g_term = 4'd5; g_mode = 1'b0;
        step(0, 0, 0, 0,  1, 1, 0, c_RUN,    "C_cnt1");
        step(0, 0, 0, 0,  2, 1, 0, c_RUN,    "C_cnt2");
        step(0, 1, 0, 0,  2, 1, 0, c_PAUSED, "C_pause1");
        step(0, 1, 0, 0,  2, 1, 0, c_PAUSED, "C_pause2");
        step(1, 1, 0, 0,  2, 1, 0, c_PAUSED, "C_pause_over_start");
        step(1, 0, 0, 0,  2, 1, 0, c_RUN,    "C_resume");
        step(0, 0, 0, 0,  3, 1, 0, c_RUN,    "C_cnt3");
        step(0, 0, 0, 0,  4, 1, 0, c_RUN,    "C_cnt4");
        step(0, 0, 0, 0,  5, 1, 0, c_RUN,    "C_cnt5");
        step(0, 0, 0, 0,  5, 0, 1, c_DONE,   "C_done");
        step(0, 0, 0, 0,  5, 0, 0, c_IDLE,   "C_idle");

        // Load in IDLE, start clears it
        g_term = 4'd1;
        step(0, 1, 1, 14, 14, 0, 0, c_IDLE, "D_load_idle");
        step(1, 0, 0, 0,   0, 1, 0, c_RUN,  "D_start_clears");
        step(0, 0, 0, 0,   1, 1, 0, c_RUN,  "D_cnt1");
        step(0, 0, 0, 0,   1, 0, 1, c_DONE, "D_done");
        step(0, 1, 1, 7,   1, 0, 0, c_IDLE, "D_done_ignores_load");

        // Load while PAUSED, resume through the wrap
        step(1, 0, 0, 0,   0, 1, 0, c_RUN,    "E_start");
        step(0, 1, 0, 0,   0, 1, 0, c_PAUSED, "E_pause");
        step(0, 0, 1, 14, 14, 1, 0, c_PAUSED, "E_load_paused");
        step(1, 0, 0, 0,  14, 1, 0, c_RUN,    "E_resume");
        step(0, 0, 0, 0,  15, 1, 0, c_RUN,    "E_cnt15");
        step(0, 0, 0, 0,   0, 1, 0, c_RUN,    "E_wrap_no_done");
        step(0, 0, 0, 0,   1, 1, 0, c_RUN,    "E_cnt1");
        step(0, 0, 0, 0,   1, 0, 1, c_DONE,   "E_done");
        g_term = 4'd9;
        step(1, 0, 1, 3,   0, 1, 0, c_RUN,    "E_done_restart");
        for (int v = 1; v <= 5; v++)
            step(0, 0, 0, 0, 4'(v), 1, 0, c_RUN, "E_count");

        // Asynchronous clear at Q=5
        async_clear("F_async_clear");
        step(1, 0, 0, 0,   0, 0, 0, c_IDLE, "F_clear_held");
        g_clear = 1'b0;
        step(1, 0, 0, 0,   0, 1, 0, c_RUN,  "F_first_edge");

        // term=0 cases
        g_term = 4'd0;
        step(0, 0, 0, 0,   0, 0, 1, c_DONE, "G_term0_oneshot");
        step(0, 0, 0, 0,   0, 0, 0, c_IDLE, "G_idle");
        step(0, 0, 1, 6,   6, 0, 0, c_IDLE, "G_load");
        g_mode = 1'b1;
        step(1, 0, 1, 9,   0, 1, 0, c_RUN,  "G_start_wins");
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 1, 1, c_RUN, "G_done_every_cycle");
        step(0, 1, 0, 0,   0, 1, 0, c_PAUSED, "G_pause");
        step(1, 0, 0, 0,   0, 1, 0, c_RUN,    "G_resume");
        step(0, 0, 0, 0,   0, 1, 1, c_RUN,    "G_done_again");
        async_clear("G_async_clear_done");
        g_clear = 1'b0;
        step(0, 0, 0, 0,   0, 0, 0, c_IDLE, "G_release");

        // Lower term below Q mid-run: counting continues through the wrap
        g_term = 4'd15; g_mode = 1'b0;
        step(1, 0, 0, 0,   0, 1, 0, c_RUN, "H_start");
        for (int v = 1; v <= 4; v++)
            step(0, 0, 0, 0, 4'(v), 1, 0, c_RUN, "H_count");
        g_term = 4'd2;
        for (int v = 5; v <= 15; v++)
            step(0, 0, 0, 0, 4'(v), 1, 0, c_RUN, "H_above_term");
        step(0, 0, 0, 0,   0, 1, 0, c_RUN,  "H_wrap");
        step(0, 0, 0, 0,   1, 1, 0, c_RUN,  "H_cnt1");
        step(0, 0, 0, 0,   2, 1, 0, c_RUN,  "H_cnt2");
        step(0, 0, 0, 0,   2, 0, 1, c_DONE, "H_done");
        step(0, 0, 0, 0,   2, 0, 0, c_IDLE, "H_idle");

        repeat (3) @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clear, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, which starts a count from IDLE/DONE or resumes from PAUSED.
REQ-005 The block SHALL have port pause, input, 1, which suspends counting while in RUN.
REQ-006 The block SHALL have port load_en, input, 1, which loads load_val into Q in IDLE or PAUSED.
REQ-007 The block SHALL have port load_val, input, WIDTH, the preset value for Q.
REQ-008 The block SHALL have port term, input, WIDTH, the terminal count, sampled every cycle.
REQ-009 The block SHALL have port mode, input, 1, selecting one-shot (0) or periodic (1) operation.
REQ-010 The block SHALL have port Q, output, WIDTH, the registered count value.
REQ-011 The block SHALL have port busy, output, 1, asserted in RUN or PAUSED.
REQ-012 The block SHALL have port done, output, 1, a registered one-cycle terminal-count pulse.
REQ-013 The block SHALL have port state, output, 2, the FSM state: IDLE=00, RUN=01, PAUSED=10, DONE=11.

Function
REQ-014 In IDLE, start SHALL set Q to 0 and enter RUN; otherwise load_en SHALL set Q to load_val and stay in IDLE; otherwise Q holds.
REQ-015 In RUN, pause SHALL enter PAUSED with Q held, taking priority over increment and the terminal check.
REQ-016 In RUN without pause, if Q==term and mode=0, Q SHALL hold, the FSM SHALL enter DONE and done SHALL be 1 in the following cycle.
REQ-017 In RUN without pause, if Q==term and mode=1, Q SHALL become 0, the FSM SHALL stay in RUN and done SHALL be 1 in the following cycle.
REQ-018 In RUN without pause, if Q!=term, Q SHALL become (Q+1) mod 2^WIDTH; wrap from all-ones to 0 is legal and does not by itself assert done.
REQ-019 In PAUSED, pause SHALL take priority and hold the state; else start SHALL resume RUN without modifying Q; else load_en SHALL load load_val; else Q holds.
REQ-020 DONE SHALL last exactly one cycle: start SHALL set Q to 0 and enter RUN, otherwise the FSM SHALL enter IDLE with Q held at term.
REQ-021 load_en SHALL be ignored in RUN and DONE; start SHALL be ignored in RUN; pause SHALL be ignored in IDLE and DONE.
REQ-022 done SHALL be 1 for exactly one cycle per terminal event and 0 at all other times.
REQ-023 From RUN entry with Q=0, the first done SHALL occur term+1 cycles later; with term=0 and mode=1, done SHALL be 1 every cycle.
REQ-024 A term change during RUN SHALL take effect on the next comparison; if Q is already above the new term, counting SHALL continue through wrap until Q equals term.
REQ-025 busy and state SHALL be decoded from the registered FSM state with no combinational path from inputs.

Reset
REQ-026 clear=1 SHALL immediately, regardless of clock, force state=IDLE, Q=0, done=0 and busy=0, including mid-count.
REQ-027 After clear deasserts, the first rising edge SHALL act on the inputs as in IDLE.

Verification
REQ-028 WIDTH=4, mode=0, term=3, pulse start -> Q sequence 0,1,2,3 with busy=1, then done=1 for one cycle with state=DONE, then IDLE with Q=3.
REQ-029 mode=1, term=2, hold in RUN for 9 cycles -> Q cycles 0,1,2,0,1,2,... with done pulsing every third cycle, after each Q=2.
REQ-030 While Q=2 in RUN, assert pause for 3 cycles, then start -> Q holds 2 with state=PAUSED, then resumes at 3 with no reset to 0.
REQ-031 In IDLE, load_en with load_val=14 and term=1, mode=0: load Q=14, then start -> Q=0 (start clears), counts to 1, done; separately in PAUSED load 14 then resume -> 14,15,0,1, then done.
REQ-032 Assert clear asynchronously mid-count at Q=5 -> Q=0, state=00 and done=0 immediately, before the next edge.
REQ-033 term=0, mode=1, start -> Q stays 0 and done=1 every cycle from the second RUN cycle; start and load_en together in IDLE -> start wins and Q=0.
